spi_dac_master: RTL and testbench
=================================

# spi_dac_master

Single-word SPI transmit/receive master that serialises the 24-bit DAC command words produced by the DAC command sequencer and drives them onto the DAC's serial pins. It accepts a word on a one-cycle `start` strobe, shifts it out MSB-first in SPI mode 1, and returns a one-cycle `new_data` completion pulse that the sequencer uses to advance to the next command. Chip-select is owned by the sequencer; this block drives only `sck` and `mosi` and samples `miso`.

## Interface
- `CLK_DIV`, 4, `clk` cycles per `sck` half-period; legal range 2..255.
- `WORD_WIDTH`, 24, bits per transfer; fixed at 24 for the DAC, parameterised for reuse.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle request; sampled only while idle.
- `data_in`  in  WORD_WIDTH  word to transmit; captured in the `start` cycle.
- `busy`  out  1  high while a transfer is in progress.
- `new_data`  out  1  one-cycle pulse: transfer complete, `data_out` valid.
- `data_out`  out  WORD_WIDTH  word shifted in from `miso` during the last transfer.
- `sck`  out  1  serial clock, idle low.
- `mosi`  out  1  serial data to DAC.
- `miso`  in  1  serial data from DAC (readback; may be unconnected, tied 0).

## Operation
- States: IDLE, TRANSFER.
- IDLE: `sck`=0, `mosi`=0, `busy`=0. On `start`=1: load tx shift register with `data_in`, clear bit counter (0..WORD_WIDTH-1) and divider counter (0..CLK_DIV-1), go to TRANSFER.
- TRANSFER: divider counts every cycle; when it reaches CLK_DIV-1 it wraps to 0 and `sck` toggles.
  - On each rising `sck` toggle: `mosi` <= tx[MSB]; tx shifts left by one.
  - On each falling `sck` toggle: rx <= {rx[WORD_WIDTH-2:0], `miso`}; bit counter increments.
  - On the falling toggle with bit counter = WORD_WIDTH-1: `data_out` <= final rx value, `new_data` pulses, `mosi` <= 0, state -> IDLE.
- Mode 1 (CPOL=0, CPHA=1): `mosi` changes on `sck` rise, stable across the following fall where the DAC latches it.
- `start` while `busy`=1: ignored; no queueing, no effect on the transfer in flight.
- `data_in` changes after the `start` cycle: no effect.
- Reset (any time, including mid-transfer): state IDLE, `sck`=0, `mosi`=0, `busy`=0, `new_data`=0, `data_out`=0, all counters and shift registers 0. A truncated frame is not completed; the sequencer must deassert chip-select.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- `start` high in cycle 0 -> `busy`=1 from cycle 1.
- First `sck` rise registered at cycle CLK_DIV+1 (the DAC sees chip-select low at least CLK_DIV-1 cycles before the first edge when the sequencer drops it one cycle after `start`; hence CLK_DIV >= 2).
- `sck` period = 2*CLK_DIV cycles, 50% duty; exactly WORD_WIDTH rising and WORD_WIDTH falling edges per frame.
- Last fall and `new_data`=1 both occur in cycle N = 1 + 2*WORD_WIDTH*CLK_DIV (193 for the defaults). `busy`=0 in cycle N.
- `start` in cycle N is accepted (back-to-back frames); minimum frame-to-frame spacing is N cycles.
- `data_out` holds its value until the next completion or reset.

## Structure
- Shared package `spi_dac_pkg`: `SPI_WORD_WIDTH`=24, state encoding (IDLE=1'b0, TRANSFER=1'b1), default `CLK_DIV`.
- One sub-module: `spi_sck_divider`. It holds the divider counter and `sck` register and emits one-cycle `rise_en`/`fall_en` strobes. The shift and bit-count logic stays in the top module.

## Test plan
- Reset with defaults: `start`=1, `data_in`=24'h280001. Check that `mosi` bits sampled at `sck` falls read 0x280001 MSB-first. There are 24 rises and 24 falls, `sck` half-period is 4 cycles, `new_data` pulses exactly once at cycle 193, and `busy` is high for cycles 1..192.
- Tie `miso` to a model shifting out 24'hA5C3F0 on `sck` rises. Check that `data_out`=24'hA5C3F0 at the `new_data` cycle.
- Pulse `start` with 24'h123456 at cycle 50 of a transfer of 24'h300015. Check that the frame carries 0x300015 unaltered and only one `new_data` pulse occurs.
- Issue `start` in the `new_data` cycle with 24'h38000F, then 24'h310054. Check both frames back-to-back, with `sck` low for exactly CLK_DIV+1 cycles between the last fall and the next rise.
- Assert `rst` asynchronously at cycle 100 of a transfer. Check `sck`=0, `mosi`=0, `busy`=0, `data_out`=0 immediately, with no `new_data` pulse; a following `start` produces a complete correct frame.
- Run with CLK_DIV=2 and word 24'hFFFFFF. Check `sck` period of 4 cycles, `new_data` at cycle 97, and `mosi` returning to 0 at completion.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// Shared constants and state encoding for the DAC SPI master.
package spi_dac_pkg;

  localparam int SPI_WORD_WIDTH      = 24;
  localparam int SPI_DEFAULT_CLK_DIV = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_TRANSFER = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sck_divider.sv
// Serial clock generator: divides clk by 2*CLK_DIV and flags each sck edge one cycle ahead.
module spi_sck_divider
  import spi_dac_pkg::*;
#(
  parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise_en,
  output logic o_fall_en
);

  localparam int CNT_W = 8;

  logic [CNT_W-1:0] r_div;
  logic             r_sck;
  logic             w_wrap;

  assign w_wrap = i_en && (r_div == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (i_clr) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_div <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_div <= r_div + CNT_W'(1);
      end
    end
  end

  // Strobes are valid in the cycle before sck actually changes, so the
  // shift logic updates on the same clock edge as the sck register.
  assign o_rise_en = w_wrap && !r_sck;
  assign o_fall_en = w_wrap &&  r_sck;
  assign o_sck     = r_sck;

endmodule

// File: rtl/spi_dac_master.sv
// Single-word SPI mode-1 master: shifts a command word out MSB-first and captures readback.
module spi_dac_master
  import spi_dac_pkg::*;
#(
  parameter int CLK_DIV    = SPI_DEFAULT_CLK_DIV,
  parameter int WORD_WIDTH = SPI_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  new_data,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int BIT_W = $clog2(WORD_WIDTH);

  spi_state_e            r_state;
  spi_state_e            w_next_state;
  logic [WORD_WIDTH-1:0] r_tx;
  logic [WORD_WIDTH-1:0] r_rx;
  logic [WORD_WIDTH-1:0] r_data_out;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_mosi;
  logic                  r_new_data;

  logic                  w_start_acc;
  logic                  w_in_xfer;
  logic                  w_rise_en;
  logic                  w_fall_en;
  logic                  w_last_fall;
  logic                  w_sck;
  logic [WORD_WIDTH-1:0] w_rx_next;

  assign w_in_xfer   = (r_state == ST_TRANSFER);
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_rx_next   = {r_rx[WORD_WIDTH-2:0], miso};
  assign w_last_fall = w_in_xfer && w_fall_en &&
                       (r_bit_cnt == BIT_W'(WORD_WIDTH - 1));

  spi_sck_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_divider (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start_acc),
    .i_en      (w_in_xfer),
    .o_sck     (w_sck),
    .o_rise_en (w_rise_en),
    .o_fall_en (w_fall_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == ST_IDLE) begin
      if (start) begin
        w_next_state = ST_TRANSFER;
      end
    end else begin
      if (w_last_fall) begin
        w_next_state = ST_IDLE;
      end
    end
  end

  // Shift path: mosi moves on sck rise, miso is sampled on sck fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_bit_cnt  <= '0;
      r_mosi     <= 1'b0;
      r_new_data <= 1'b0;
    end else begin
      r_new_data <= 1'b0;
      if (w_start_acc) begin
        r_tx      <= data_in;
        r_rx      <= '0;
        r_bit_cnt <= '0;
        r_mosi    <= 1'b0;
      end else if (w_in_xfer) begin
        if (w_rise_en) begin
          r_mosi <= r_tx[WORD_WIDTH-1];
          r_tx   <= {r_tx[WORD_WIDTH-2:0], 1'b0};
        end
        if (w_fall_en) begin
          r_rx      <= w_rx_next;
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          if (w_last_fall) begin
            r_data_out <= w_rx_next;
            r_new_data <= 1'b1;
            r_mosi     <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end
      end
    end
  end

  assign busy     = w_in_xfer;
  assign new_data = r_new_data;
  assign data_out = r_data_out;
  assign sck      = w_sck;
  assign mosi     = r_mosi;

endmodule

// File: tb/tb_spi_dac_master.sv
// Bench for spi_dac_master: records per-cycle traces and measures them against frame rules.
module tb_spi_dac_master;

  localparam int W     = 24;
  localparam int DIV_A = 4;
  localparam int DIV_B = 2;
  localparam int NA    = 1 + 2 * W * DIV_A;
  localparam int NB    = 1 + 2 * W * DIV_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_start, a_miso, a_busy, a_nd, a_sck, a_mosi;
  logic [W-1:0]  a_din, a_dout;
  logic          b_rst, b_start, b_miso, b_busy, b_nd, b_sck, b_mosi;
  logic [W-1:0]  b_din, b_dout;

  spi_dac_master #(.CLK_DIV(DIV_A), .WORD_WIDTH(W)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .data_in(a_din), .busy(a_busy),
    .new_data(a_nd), .data_out(a_dout), .sck(a_sck), .mosi(a_mosi), .miso(a_miso));

  spi_dac_master #(.CLK_DIV(DIV_B), .WORD_WIDTH(W)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .data_in(b_din), .busy(b_busy),
    .new_data(b_nd), .data_out(b_dout), .sck(b_sck), .mosi(b_mosi), .miso(b_miso));

  int checks = 0;
  int errors = 0;

  logic         tr_sck  [0:511];
  logic         tr_mosi [0:511];
  logic         tr_busy [0:511];
  logic         tr_nd   [0:511];
  logic [W-1:0] tr_dout [0:511];

  int           m_rises, m_falls, m_first_rise, m_last_fall;
  int           m_hi_min, m_hi_max, m_lo_min, m_lo_max;
  int           m_nd_cnt, m_nd_cyc, m_busy_cnt;
  logic         m_busy_end, m_mosi_end;
  logic [W-1:0] m_mosi_word, m_dout;

  task automatic drive(input bit sel, input logic st, input logic [W-1:0] d, input logic m);
    if (sel) begin b_start = st; b_din = d; b_miso = m; end
    else     begin a_start = st; a_din = d; a_miso = m; end
  endtask

  // Slave model: on every sck rise the next readback bit (MSB-first) appears on miso.
  task automatic capture(input bit sel, input int ncyc, input int s0, input logic [W-1:0] w0,
                         input int s1, input logic [W-1:0] w1, input int inj,
                         input logic [W-1:0] winj, input logic [W-1:0] slave);
    logic         m;
    logic         st;
    logic [W-1:0] d;
    logic [W-1:0] sw;
    m  = 1'b0;
    sw = slave;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tr_sck[c]  = sel ? b_sck  : a_sck;
      tr_mosi[c] = sel ? b_mosi : a_mosi;
      tr_busy[c] = sel ? b_busy : a_busy;
      tr_nd[c]   = sel ? b_nd   : a_nd;
      tr_dout[c] = sel ? b_dout : a_dout;
      if (c > 0 && tr_sck[c] && !tr_sck[c-1]) begin
        m  = sw[W-1];
        sw = sw << 1;
      end
      st = 1'b0;
      d  = W'($urandom);
      if (c == s0)       begin st = 1'b1; d = w0;   sw = slave; end
      else if (c == s1)  begin st = 1'b1; d = w1;   sw = slave; end
      else if (c == inj) begin st = 1'b1; d = winj; end
      drive(sel, st, d, m);
    end
  endtask

  // Measures the recorded window base+1 .. base+len (no comparisons here).
  task automatic analyze(input int base, input int len);
    int last_rise;
    int last_fall;
    last_rise = -1; last_fall = -1;
    m_rises = 0; m_falls = 0; m_first_rise = -1; m_last_fall = -1;
    m_hi_min = 1000000; m_hi_max = 0; m_lo_min = 1000000; m_lo_max = 0;
    m_nd_cnt = 0; m_nd_cyc = -1; m_busy_cnt = 0; m_mosi_word = '0; m_dout = '0;
    for (int c = base + 1; c <= base + len; c++) begin
      if (tr_sck[c] && !tr_sck[c-1]) begin
        m_rises++;
        if (m_first_rise < 0) m_first_rise = c - base;
        if (last_fall >= 0) begin
          if (c - last_fall < m_lo_min) m_lo_min = c - last_fall;
          if (c - last_fall > m_lo_max) m_lo_max = c - last_fall;
        end
        last_rise = c;
      end
      if (!tr_sck[c] && tr_sck[c-1]) begin
        m_falls++;
        m_mosi_word = {m_mosi_word[W-2:0], tr_mosi[c-1]};
        if (last_rise >= 0) begin
          if (c - last_rise < m_hi_min) m_hi_min = c - last_rise;
          if (c - last_rise > m_hi_max) m_hi_max = c - last_rise;
        end
        last_fall = c;
        m_last_fall = c - base;
      end
      if (tr_nd[c]) begin
        m_nd_cnt++;
        m_nd_cyc = c - base;
        m_dout = tr_dout[c];
      end
      if (tr_busy[c] && c < base + len) m_busy_cnt++;
    end
    m_busy_end = tr_busy[base + len];
    m_mosi_end = tr_mosi[base + len];
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_sck, a_mosi, a_nd, a_dout} !== '0) begin
      errors++; $display("FAIL reset_a_outputs got %h want 0", {a_busy, a_sck, a_mosi, a_nd, a_dout});
    end
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b_busy, b_sck, b_mosi, b_nd, b_dout} !== '0) begin
      errors++; $display("FAIL reset_b_outputs got %h want 0", {b_busy, b_sck, b_mosi, b_nd, b_dout});
    end
  endtask

  task automatic test_basic();
    capture(0, NA + 3, 0, 24'h280001, -1, '0, -1, '0, '0);
    analyze(0, NA);
    checks++; if (m_mosi_word !== 24'h280001) begin errors++; $display("FAIL basic_mosi_word got %h want 280001", m_mosi_word); end
    checks++; if (m_rises !== W || m_falls !== W) begin errors++; $display("FAIL basic_edges got %0d/%0d want %0d/%0d", m_rises, m_falls, W, W); end
    checks++; if (m_first_rise !== DIV_A + 1) begin errors++; $display("FAIL basic_first_rise got %0d want %0d", m_first_rise, DIV_A + 1); end
    checks++; if (m_last_fall !== NA) begin errors++; $display("FAIL basic_last_fall got %0d want %0d", m_last_fall, NA); end
    checks++;
    if (m_hi_min !== DIV_A || m_hi_max !== DIV_A || m_lo_min !== DIV_A || m_lo_max !== DIV_A) begin
      errors++; $display("FAIL basic_half_period got hi %0d..%0d lo %0d..%0d want %0d", m_hi_min, m_hi_max, m_lo_min, m_lo_max, DIV_A);
    end
    checks++; if (m_nd_cnt !== 1 || m_nd_cyc !== NA) begin errors++; $display("FAIL basic_new_data got cnt %0d cyc %0d want 1 at %0d", m_nd_cnt, m_nd_cyc, NA); end
    checks++; if (m_busy_cnt !== NA - 1 || m_busy_end !== 1'b0 || tr_busy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_busy got %0d cycles end %b want %0d end 0", m_busy_cnt, m_busy_end, NA - 1);
    end
    checks++; if (m_mosi_end !== 1'b0) begin errors++; $display("FAIL basic_mosi_end got %b want 0", m_mosi_end); end
  endtask

  task automatic test_readback();
    capture(0, NA + 6, 0, 24'h3A0C11, -1, '0, -1, '0, 24'hA5C3F0);
    analyze(0, NA);
    checks++; if (m_nd_cyc !== NA || m_dout !== 24'hA5C3F0) begin errors++; $display("FAIL readback_dout got %h at %0d want a5c3f0 at %0d", m_dout, m_nd_cyc, NA); end
    checks++; if (tr_dout[NA + 5] !== 24'hA5C3F0) begin errors++; $display("FAIL readback_hold got %h want a5c3f0", tr_dout[NA + 5]); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w;
    logic [W-1:0] s;
    int           nd_seen;
    int           busy_seen;
    capture(0, 102, 0, 24'h3FF0AA, -1, '0, -1, '0, 24'h5A5A5A);
    @(posedge clk);
    #1;
    checks++; if ({a_busy, a_sck} !== 2'b11) begin errors++; $display("FAIL areset_pre got busy %b sck %b want 1 1", a_busy, a_sck); end
    #1 a_rst = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_sck, a_mosi, a_nd, a_dout} !== '0) begin
      errors++; $display("FAIL areset_immediate got %h want 0", {a_busy, a_sck, a_mosi, a_nd, a_dout});
    end
    @(negedge clk);
    a_rst = 1'b0;
    nd_seen = 0; busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_nd) nd_seen++;
      if (a_busy) busy_seen++;
    end
    checks++; if (nd_seen !== 0 || busy_seen !== 0) begin errors++; $display("FAIL areset_quiet got nd %0d busy %0d want 0 0", nd_seen, busy_seen); end
    w = W'($urandom); s = W'($urandom);
    capture(0, NA + 2, 0, w, -1, '0, -1, '0, s);
    analyze(0, NA);
    checks++;
    if (m_mosi_word !== w || m_dout !== s || m_nd_cyc !== NA || m_nd_cnt !== 1) begin
      errors++; $display("FAIL areset_after got mosi %h dout %h nd %0d@%0d want %h %h 1@%0d", m_mosi_word, m_dout, m_nd_cnt, m_nd_cyc, w, s, NA);
    end
  endtask

  task automatic test_start_ignored();
    capture(0, NA + 12, 0, 24'h300015, -1, '0, 50, 24'h123456, '0);
    analyze(0, NA + 11);
    checks++; if (m_mosi_word !== 24'h300015) begin errors++; $display("FAIL ignored_mosi got %h want 300015", m_mosi_word); end
    checks++; if (m_nd_cnt !== 1 || m_rises !== W) begin errors++; $display("FAIL ignored_single_frame got nd %0d rises %0d want 1 %0d", m_nd_cnt, m_rises, W); end
    checks++; if (m_busy_cnt !== NA - 1) begin errors++; $display("FAIL ignored_busy got %0d want %0d", m_busy_cnt, NA - 1); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s;
    logic [W-1:0] mw1;
    int           lf1;
    int           nd1;
    s = W'($urandom) | 24'h1;
    capture(0, 2 * NA + 3, 0, 24'h38000F, NA, 24'h310054, -1, '0, s);
    analyze(0, NA);
    mw1 = m_mosi_word; lf1 = m_last_fall; nd1 = m_nd_cnt;
    checks++; if (mw1 !== 24'h38000F || nd1 !== 1 || m_dout !== s) begin errors++; $display("FAIL b2b_frame1 got %h nd %0d dout %h want 38000f 1 %h", mw1, nd1, m_dout, s); end
    analyze(NA, NA);
    checks++; if (m_mosi_word !== 24'h310054 || m_dout !== s) begin errors++; $display("FAIL b2b_frame2 got %h dout %h want 310054 %h", m_mosi_word, m_dout, s); end
    checks++; if (m_nd_cnt !== 1 || m_nd_cyc !== NA) begin errors++; $display("FAIL b2b_new_data2 got cnt %0d cyc %0d want 1 %0d", m_nd_cnt, m_nd_cyc, NA); end
    checks++; if (NA + m_first_rise - lf1 !== DIV_A + 1) begin errors++; $display("FAIL b2b_gap got %0d want %0d", NA + m_first_rise - lf1, DIV_A + 1); end
  endtask

  task automatic test_div2();
    logic [W-1:0] s;
    s = W'($urandom);
    capture(1, NB + 3, 0, 24'hFFFFFF, -1, '0, -1, '0, s);
    analyze(0, NB);
    checks++;
    if (m_hi_min !== DIV_B || m_hi_max !== DIV_B || m_lo_min !== DIV_B || m_lo_max !== DIV_B) begin
      errors++; $display("FAIL div2_half_period got hi %0d..%0d lo %0d..%0d want %0d", m_hi_min, m_hi_max, m_lo_min, m_lo_max, DIV_B);
    end
    checks++; if (m_nd_cyc !== NB || m_nd_cnt !== 1) begin errors++; $display("FAIL div2_new_data got %0d@%0d want 1@%0d", m_nd_cnt, m_nd_cyc, NB); end
    checks++; if (m_mosi_word !== 24'hFFFFFF || m_mosi_end !== 1'b0) begin errors++; $display("FAIL div2_mosi got %h end %b want ffffff end 0", m_mosi_word, m_mosi_end); end
    checks++; if (m_dout !== s || m_first_rise !== DIV_B + 1) begin errors++; $display("FAIL div2_dout got %h rise %0d want %h rise %0d", m_dout, m_first_rise, s, DIV_B + 1); end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    logic [W-1:0] s;
    bit           sel;
    int           n;
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      n   = sel ? NB : NA;
      w   = W'($urandom); s = W'($urandom);
      repeat ($urandom_range(3)) @(negedge clk);
      capture(sel, n + 2, 0, w, -1, '0, -1, '0, s);
      analyze(0, n);
      checks++;
      if (m_mosi_word !== w || m_dout !== s || m_nd_cyc !== n || m_rises !== W) begin
        errors++; $display("FAIL random_%0d got mosi %h dout %h nd@%0d rises %0d want %h %h %0d %0d", i, m_mosi_word, m_dout, m_nd_cyc, m_rises, w, s, n, W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_async_reset();
    test_start_ignored();
    test_back_to_back();
    test_div2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
